// File: rtl/tx_skip_inserter.sv
// Periodic SKP ordered-set inserter for an 8b/10b transmit path: forwards upstream
// symbols one per clock and splices COM + SKP_COUNT x SKP every SKIP_INTERVAL symbols.
module tx_skip_inserter #(
    parameter int SKIP_INTERVAL = 1180,
    parameter int SKP_COUNT     = 3
) (
    input  logic       BitCLK_10,
    input  logic       Reset,
    input  logic [7:0] TxParallel_8_in,
    input  logic       TxDataK_in,
    input  logic       TxValid_in,
    input  logic       TxSkipEn,
    output logic       TxReady_out,
    output logic [7:0] TxParallel_8_out,
    output logic       TxDataK_out,
    output logic       Idle_out,
    output logic       SkipSent
);

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_SKP  = 1'b1
    } state_e;

    localparam logic [7:0]  COM_SYM   = 8'hBC;
    localparam logic [7:0]  SKP_SYM   = 8'h1C;
    localparam logic [7:0]  IDLE_SYM  = 8'h00;
    localparam logic [10:0] CNT_LAST  = 11'(SKIP_INTERVAL - 1);
    localparam logic [2:0]  SCNT_LAST = 3'(SKP_COUNT - 1);

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [2:0]  scnt_q, scnt_d;
    logic [7:0]  data_q, data_d;
    logic        k_q, k_d;
    logic        idle_q, idle_d;
    logic        sent_q, sent_d;
    logic        skip_due;

    // The ordered set wins the slot once the interval is exhausted; upstream is stalled.
    assign skip_due    = TxSkipEn & (state_q == ST_DATA) & (cnt_q == CNT_LAST);
    assign TxReady_out = ~Reset & (state_q == ST_DATA) & ~skip_due;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        data_d  = IDLE_SYM;
        k_d     = 1'b0;
        idle_d  = 1'b0;
        sent_d  = 1'b0;

        unique case (state_q)
            ST_DATA: begin
                if (skip_due) begin
                    data_d  = COM_SYM;
                    k_d     = 1'b1;
                    cnt_d   = '0;
                    scnt_d  = '0;
                    state_d = ST_SKP;
                end else begin
                    if (TxValid_in) begin
                        data_d = TxParallel_8_in;
                        k_d    = TxDataK_in;
                    end else begin
                        idle_d = 1'b1;
                    end
                    cnt_d = TxSkipEn ? cnt_q + 11'd1 : '0;
                end
            end
            ST_SKP: begin
                // A started ordered set always runs to completion, whatever TxSkipEn does.
                data_d = SKP_SYM;
                k_d    = 1'b1;
                scnt_d = scnt_q + 3'd1;
                if (scnt_q == SCNT_LAST) begin
                    sent_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples its _d value from before the edge regardless of statement order.
    always_ff @(posedge BitCLK_10) begin
        if (Reset) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            scnt_q  <= '0;
            data_q  <= IDLE_SYM;
            k_q     <= 1'b0;
            idle_q  <= 1'b1;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            data_q  <= data_d;
            k_q     <= k_d;
            idle_q  <= idle_d;
            sent_q  <= sent_d;
        end
    end

    assign TxParallel_8_out = data_q;
    assign TxDataK_out      = k_q;
    assign Idle_out         = idle_q;
    assign SkipSent         = sent_q;

endmodule

// File: tb/tb_tx_skip_inserter.sv
// Directed bench for tx_skip_inserter with SKIP_INTERVAL=8, SKP_COUNT=3 (period 11).
module tb_tx_skip_inserter;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       kin;
    logic       vin;
    logic       en;
    logic       rdy;
    logic [7:0] dout;
    logic       kout;
    logic       idle;
    logic       sent;
    logic [10:0] obs;

    int checks   = 0;
    int failures = 0;

    tx_skip_inserter #(
        .SKIP_INTERVAL(8),
        .SKP_COUNT    (3)
    ) dut (
        .BitCLK_10       (clk),
        .Reset           (rst),
        .TxParallel_8_in (din),
        .TxDataK_in      (kin),
        .TxValid_in      (vin),
        .TxSkipEn        (en),
        .TxReady_out     (rdy),
        .TxParallel_8_out(dout),
        .TxDataK_out     (kout),
        .Idle_out        (idle),
        .SkipSent        (sent)
    );

    // {data, K, idle, SkipSent}
    assign obs = {dout, kout, idle, sent};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vin = 1'b0;
        en  = 1'b0;
        din = 8'h00;
        kin = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Expected output for cycle position p of a period-11 ordered-set cycle (p >= 7).
    function automatic logic [10:0] os_exp(input int p);
        if (p == 7)       return {8'hBC, 1'b1, 1'b0, 1'b0};
        else if (p == 10) return {8'h1C, 1'b1, 1'b0, 1'b1};
        else              return {8'h1C, 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; vin = 1'b1; din = 8'hA5; kin = 1'b1; en = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0", rdy);
        end
        tick();
        checks++;
        if (obs !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", obs, {8'h00, 1'b0, 1'b1, 1'b0});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected 1", rdy);
        end
    endtask

    task automatic test_data_stream();
        logic [7:0]  nb;
        logic [10:0] exp;
        logic        exp_rdy;
        do_reset();
        en = 1'b1; vin = 1'b1; kin = 1'b0; nb = 8'h01;
        for (int i = 0; i < 12; i++) begin
            din = nb;
            #1;
            exp_rdy = !(i >= 7 && i <= 10);
            checks++;
            if (rdy !== exp_rdy) begin
                failures++;
                $display("FAIL stream_ready[%0d]: got %b expected %b", i, rdy, exp_rdy);
            end
            tick();
            if (i < 7)       exp = {8'(i + 1), 1'b0, 1'b0, 1'b0};
            else if (i < 11) exp = os_exp(i);
            else             exp = {8'h08, 1'b0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL stream_out[%0d]: got %h expected %h", i, obs, exp);
            end
            if (exp_rdy) nb = nb + 8'd1;
        end
    endtask

    task automatic test_idle();
        logic [10:0] exp;
        logic        exp_rdy;
        int          p;
        do_reset();
        en = 1'b1; vin = 1'b0; din = 8'hFF; kin = 1'b1;
        for (int i = 0; i < 22; i++) begin
            p = i % 11;
            #1;
            exp_rdy = (p < 7);
            checks++;
            if (rdy !== exp_rdy) begin
                failures++;
                $display("FAIL idle_ready[%0d]: got %b expected %b", i, rdy, exp_rdy);
            end
            tick();
            exp = (p < 7) ? {8'h00, 1'b0, 1'b1, 1'b0} : os_exp(p);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL idle_out[%0d]: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_skip_disabled();
        logic [10:0] exp;
        logic        exp_rdy;
        do_reset();
        en = 1'b0; vin = 1'b1; kin = 1'b0;
        for (int i = 0; i < 50; i++) begin
            din = 8'(i + 1);
            #1;
            checks++;
            if (rdy !== 1'b1) begin
                failures++;
                $display("FAIL noskip_ready[%0d]: got %b expected 1", i, rdy);
            end
            tick();
            exp = {8'(i + 1), 1'b0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL noskip_out[%0d]: got %h expected %h", i, obs, exp);
            end
        end
        en = 1'b1;
        for (int j = 0; j < 9; j++) begin
            din = 8'(8'h40 + j);
            #1;
            exp_rdy = (j < 7);
            checks++;
            if (rdy !== exp_rdy) begin
                failures++;
                $display("FAIL reenable_ready[%0d]: got %b expected %b", j, rdy, exp_rdy);
            end
            tick();
            exp = (j < 7) ? {8'(8'h40 + j), 1'b0, 1'b0, 1'b0} : os_exp(j);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reenable_out[%0d]: got %h expected %h", j, obs, exp);
            end
        end
    endtask

    task automatic test_drop_after_com();
        logic [10:0] exp;
        logic        exp_rdy;
        do_reset();
        vin = 1'b0; din = 8'h00; kin = 1'b0;
        for (int i = 0; i < 31; i++) begin
            en = (i < 8);
            #1;
            exp_rdy = (i < 7) || (i >= 11);
            checks++;
            if (rdy !== exp_rdy) begin
                failures++;
                $display("FAIL drop_ready[%0d]: got %b expected %b", i, rdy, exp_rdy);
            end
            tick();
            exp = (i >= 7 && i <= 10) ? os_exp(i) : {8'h00, 1'b0, 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL drop_out[%0d]: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_skp();
        logic [10:0] exp;
        logic        exp_rdy;
        do_reset();
        en = 1'b1; vin = 1'b1; kin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = 8'(8'h60 + i);
            #1;
            exp_rdy = (i < 7);
            checks++;
            if (rdy !== exp_rdy) begin
                failures++;
                $display("FAIL midskp_ready[%0d]: got %b expected %b", i, rdy, exp_rdy);
            end
            tick();
            exp = (i < 7) ? {8'(8'h60 + i), 1'b0, 1'b0, 1'b0} : os_exp(i);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL midskp_out[%0d]: got %h expected %h", i, obs, exp);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            failures++;
            $display("FAIL midskp_reset_ready: got %b expected 0", rdy);
        end
        tick();
        checks++;
        if (obs !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL midskp_reset_out: got %h expected %h", obs, {8'h00, 1'b0, 1'b1, 1'b0});
        end
        rst = 1'b0;
        for (int j = 0; j < 9; j++) begin
            din = 8'(8'h70 + j);
            #1;
            exp_rdy = (j < 7);
            checks++;
            if (rdy !== exp_rdy) begin
                failures++;
                $display("FAIL postreset_ready[%0d]: got %b expected %b", j, rdy, exp_rdy);
            end
            tick();
            exp = (j < 7) ? {8'(8'h70 + j), 1'b0, 1'b0, 1'b0} : os_exp(j);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL postreset_out[%0d]: got %h expected %h", j, obs, exp);
            end
        end
    endtask

    task automatic test_random_scoreboard();
        logic [8:0]  sb[$];
        logic [8:0]  front;
        logic [10:0] exp;
        logic        exp_rdy;
        logic        v;
        int          p;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 110; i++) begin
            p = i % 11;
            v = 1'($urandom_range(0, 1));
            vin = v;
            if (i % 13 == 5) begin
                din = 8'hBC; kin = 1'b1;
            end else if (i % 13 == 9) begin
                din = 8'h1C; kin = 1'b1;
            end else begin
                din = 8'($urandom);
                kin = ($urandom_range(0, 3) == 0);
            end
            #1;
            exp_rdy = (p < 7);
            checks++;
            if (rdy !== exp_rdy) begin
                failures++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", i, rdy, exp_rdy);
            end
            if (v && exp_rdy) sb.push_back({kin, din});
            tick();
            if (p >= 7) begin
                exp = os_exp(p);
            end else if (v) begin
                front = sb.pop_front();
                exp = {front[7:0], front[8], 1'b0, 1'b0};
            end else begin
                exp = {8'h00, 1'b0, 1'b1, 1'b0};
            end
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rand_out[%0d]: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rand_leftover: got %0d expected 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; kin = 1'b0; vin = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_data_stream();
        test_idle();
        test_skip_disabled();
        test_drop_after_com();
        test_reset_mid_skp();
        test_random_scoreboard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
